mmio_bus: RTL

MMIO_BUS -- requirements
Module: mmio_bus

---
 rtl/bus_pkg.sv | 23 ++
 rtl/addr_dec.sv | 28 ++
 rtl/mmio_bus.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the MMIO bus: FSM state encoding, default
// slave address map and default response timeout.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bus_state_t;

    localparam int unsigned DEF_NSLV = 3;

    // Slave i occupies bits [32i+31:32i]
    localparam logic [95:0] DEF_SLV_BASE = {32'hB000_0000, 32'hA000_0000, 32'h8000_0000};
    localparam logic [95:0] DEF_SLV_MASK = {3{32'hF800_0000}};

    localparam int unsigned DEF_TMO = 255;

    // Timeout counter width, large enough for the maximum TMO of 65535
    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/addr_dec.sv
// Combinational address decoder: matches a 64-bit byte address against
// per-slave base/mask pairs; only the low 4 GiB is mappable and the lowest
// matching slave index wins.
module addr_dec #(
    parameter int unsigned NSLV = 3
) (
    input  logic [63:0]          addr,
    input  logic [32*NSLV-1:0]   base,
    input  logic [32*NSLV-1:0]   mask,
    output logic                 hit,
    output logic [NSLV-1:0]      sel
);

    // Priority match, first hit in ascending index order is kept
    always_comb begin
        hit = 1'b0;
        sel = '0;
        if (addr[63:32] == 32'h0) begin
            for (int unsigned i = 0; i < NSLV; i++) begin
                if (!hit && ((addr[31:0] & mask[32*i +: 32]) == base[32*i +: 32])) begin
                    hit    = 1'b1;
                    sel[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mmio_bus.sv
// Single-outstanding MMIO bridge from a CPU access port to NSLV slave
// channels. Requests are decoded and registered on acceptance, the selected
// slave gets a one-cycle select pulse, and exactly one response (data, slave
// error, decode error or timeout) is returned per accepted request.
module mmio_bus
    import bus_pkg::*;
#(
    parameter int unsigned          NSLV     = DEF_NSLV,
    parameter int unsigned          DATA_W   = 64,
    parameter logic [32*NSLV-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [32*NSLV-1:0]   SLV_MASK = DEF_SLV_MASK,
    parameter int unsigned          TMO      = DEF_TMO
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    acs_req,
    output logic                    acs_ready,
    input  logic                    acs_wr,
    input  logic [DATA_W/8-1:0]     acs_bytes,
    input  logic [63:0]             acs_addr,
    input  logic [DATA_W-1:0]       acs_wdata,
    output logic                    acs_rvalid,
    output logic [DATA_W-1:0]       acs_rdata,
    output logic                    acs_error,

    output logic [NSLV-1:0]         slv_cen,
    output logic                    slv_wr,
    output logic [DATA_W/8-1:0]     slv_strb,
    output logic [31:0]             slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    input  logic [NSLV-1:0]         slv_rvalid,
    input  logic [NSLV*DATA_W-1:0]  slv_rdata,
    input  logic [NSLV-1:0]         slv_error
);

    localparam int unsigned      SW     = DATA_W / 8;
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TMO - 1);

    bus_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NSLV-1:0]    sel_q;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               dec_hit;
    logic [NSLV-1:0]    dec_sel;
    logic [31:0]        dec_mask;
    logic               accept;
    logic               rsp_hit;
    logic               rsp_err;
    logic [DATA_W-1:0]  rsp_data;

    addr_dec #(
        .NSLV (NSLV)
    ) u_addr_dec (
        .addr (acs_addr),
        .base (SLV_BASE),
        .mask (SLV_MASK),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    assign accept = acs_req && (state_q == IDLE);

    // Mask of the decoded slave, used to strip its region bits from the address
    always_comb begin
        dec_mask = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (dec_sel[i]) begin
                dec_mask = dec_mask | SLV_MASK[32*i +: 32];
            end
        end
    end

    // Response from the selected channel only; other channels are ignored
    always_comb begin
        rsp_data = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                rsp_data = rsp_data | slv_rdata[DATA_W*i +: DATA_W];
            end
        end
        rsp_hit = |(slv_rvalid & sel_q);
        rsp_err = |(slv_error & sel_q);
    end

    // Next-state, timeout counter and response latch logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (acs_req) begin
                    if (dec_hit) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (rsp_hit) begin
                    state_d = RESP;
                    rdata_d = slv_wr ? '0 : rsp_data;
                    err_d   = rsp_err;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // A response in the final counted cycle takes priority over timeout
                if (rsp_hit) begin
                    state_d = RESP;
                    rdata_d = slv_wr ? '0 : rsp_data;
                    err_d   = rsp_err;
                end else if (cnt_q == TMO_M1) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request fields and slave select captured on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= '0;
            slv_wr    <= 1'b0;
            slv_strb  <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
        end else if (accept) begin
            sel_q     <= dec_sel;
            slv_wr    <= acs_wr;
            slv_strb  <= acs_bytes[SW-1:0];
            slv_addr  <= acs_addr[31:0] & ~dec_mask;
            slv_wdata <= acs_wdata;
        end
    end

    // Outputs decoded from state; response fields forced to zero outside RESP
    always_comb begin
        acs_ready  = (state_q == IDLE);
        acs_rvalid = (state_q == RESP);
        acs_rdata  = (state_q == RESP) ? rdata_q : '0;
        acs_error  = (state_q == RESP) ? err_q : 1'b0;
        slv_cen    = (state_q == ISSUE) ? sel_q : '0;
    end

endmodule
